// File: rtl/c3po_sink_pkg.sv
// -----------------------------------------------------------------------------
// c3po_sink_pkg
// Shared types and helpers for the C3PO output sink.
//   sink_state_e : reassembly FSM states (IDLE, COLLECT, DROP, HOLD)
//   err_cause_e  : reason an accepted beat was flagged as a framing error
//   BEAT_BYTES   : bytes carried by one beat
//   PKT_BYTES    : bytes in a fully reassembled packet word
//   mask_beat()  : zeroes every byte at or above the valid byte count
//   vbc_legal()  : checks a beat's valid byte count against its framing
// -----------------------------------------------------------------------------
package c3po_sink_pkg;

    localparam int BEAT_BYTES = 32;
    localparam int PKT_BYTES  = 160;
    localparam int BEAT_W     = BEAT_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DROP,
        HOLD
    } sink_state_e;

    // ERR_NONE marks a beat that raised no error.
    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_ORPHAN,
        ERR_NESTED_SOP,
        ERR_OVERFLOW,
        ERR_BAD_VBC
    } err_cause_e;

    // Keeps bytes below vbc and clears the rest. Full beats (vbc = 32) pass
    // through unchanged, so this can be applied to every stored beat.
    function automatic logic [BEAT_W-1:0] mask_beat(input logic [BEAT_W-1:0] data,
                                                    input logic [7:0]        vbc);
        logic [BEAT_W-1:0] res;
        res = '0;
        for (int b = 0; b < BEAT_BYTES; b++) begin
            if (b < int'(vbc)) begin
                res[8*b +: 8] = data[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Middle beats must be full; the closing beat may carry 1..32 bytes.
    function automatic logic vbc_legal(input logic eop, input logic [7:0] vbc);
        if (eop) begin
            return (vbc >= 8'd1) && (vbc <= 8'(BEAT_BYTES));
        end
        return vbc == 8'(BEAT_BYTES);
    endfunction

endpackage

// File: rtl/c3po_sink_sat_cnt.sv
// -----------------------------------------------------------------------------
// c3po_sink_sat_cnt
// Saturating event counter with synchronous clear.
//   clock : rising-edge clock
//   reset : synchronous active-high reset, count returns to zero
//   clr   : synchronous clear, takes priority over inc
//   inc   : count one event this cycle
//   count : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module c3po_sink_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Clear beats increment so a clear issued alongside an event still lands
    // at zero; once all-ones is reached further events are absorbed.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/c3po_out_sink.sv
// -----------------------------------------------------------------------------
// c3po_out_sink
// Reassembles 32-byte C3PO output beats into one 160-byte packet word.
//   sig_clock, sig_reset        : clock and synchronous active-high reset
//   sig_i_sop/eop/val/vbc/data  : incoming beat and its framing
//   sig_ready                   : beat backpressure, low while a packet waits
//   sig_pkt_val/ready           : packet handshake toward the consumer
//   sig_pkt_data, sig_pkt_len   : reassembled packet and its byte length
//   sig_err_pulse               : one pulse per beat with a framing error
//   sig_cnt_pkt, sig_cnt_err    : saturating delivered-packet / error counts
//   sig_clr_cnt                 : synchronous clear of both counters
// -----------------------------------------------------------------------------
module c3po_out_sink
    import c3po_sink_pkg::*;
#(
    parameter int MAX_BEATS  = 5,
    parameter int CNT_SIZE_P = 8
) (
    input  logic                        sig_clock,
    input  logic                        sig_reset,
    input  logic                        sig_i_sop,
    input  logic                        sig_i_eop,
    input  logic                        sig_i_val,
    input  logic [7:0]                  sig_i_vbc,
    input  logic [BEAT_W-1:0]           sig_i_data,
    output logic                        sig_ready,
    output logic                        sig_pkt_val,
    input  logic                        sig_pkt_ready,
    output logic [MAX_BEATS*BEAT_W-1:0] sig_pkt_data,
    output logic [7:0]                  sig_pkt_len,
    output logic                        sig_err_pulse,
    output logic [CNT_SIZE_P-1:0]       sig_cnt_pkt,
    output logic [CNT_SIZE_P-1:0]       sig_cnt_err,
    input  logic                        sig_clr_cnt
);

    localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    sink_state_e                         state;
    sink_state_e                         state_next;
    err_cause_e                          err_cause;
    logic [IDX_W-1:0]                    beat_idx;
    logic [MAX_BEATS-1:0][BEAT_W-1:0]    pkt_buf;
    logic [7:0]                          pkt_len;
    logic [7:0]                          len_next;
    logic [BEAT_W-1:0]                   beat_masked;
    logic                                err_pulse;
    logic                                beat_acc;
    logic                                vbc_ok;
    logic                                do_start;
    logic                                do_store;
    logic                                pkt_take;
    logic                                err_now;

    assign beat_acc    = sig_i_val && sig_ready;
    assign vbc_ok      = vbc_legal(sig_i_eop, sig_i_vbc);
    assign beat_masked = mask_beat(sig_i_data, sig_i_vbc);
    assign pkt_take    = (state == HOLD) && sig_pkt_ready;
    assign err_now     = (err_cause != ERR_NONE);
    assign len_next    = 8'(BEAT_BYTES * int'(beat_idx) + int'(sig_i_vbc));

    // State register.
    always_ff @(posedge sig_clock) begin
        if (sig_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control. A sop beat accepted in IDLE, COLLECT
    // or DROP runs the shared START step at the bottom; a nested sop has
    // already claimed the beat's single error, so a bad vbc on that same beat
    // only redirects the state and is not reported a second time.
    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_store   = 1'b0;
        err_cause  = ERR_NONE;
        case (state)
            IDLE: begin
                if (beat_acc) begin
                    if (sig_i_sop) begin
                        do_start = 1'b1;
                    end else begin
                        err_cause  = ERR_ORPHAN;
                        state_next = sig_i_eop ? IDLE : DROP;
                    end
                end
            end
            COLLECT: begin
                if (beat_acc) begin
                    if (sig_i_sop) begin
                        do_start  = 1'b1;
                        err_cause = ERR_NESTED_SOP;
                    end else if (!vbc_ok) begin
                        err_cause  = ERR_BAD_VBC;
                        state_next = sig_i_eop ? IDLE : DROP;
                    end else if (sig_i_eop) begin
                        do_store   = 1'b1;
                        state_next = HOLD;
                    end else if (int'(beat_idx) < MAX_BEATS - 1) begin
                        do_store = 1'b1;
                    end else begin
                        err_cause  = ERR_OVERFLOW;
                        state_next = DROP;
                    end
                end
            end
            DROP: begin
                if (beat_acc) begin
                    if (sig_i_sop) begin
                        do_start = 1'b1;
                    end else if (sig_i_eop) begin
                        state_next = IDLE;
                    end
                end
            end
            HOLD: begin
                if (sig_pkt_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (do_start) begin
            if (!vbc_ok) begin
                if (err_cause == ERR_NONE) begin
                    err_cause = ERR_BAD_VBC;
                end
                state_next = sig_i_eop ? IDLE : DROP;
            end else if (sig_i_eop) begin
                state_next = HOLD;
            end else begin
                state_next = COLLECT;
            end
        end
    end

    // Handshake outputs. Ready is forced low during reset so no beat can be
    // taken while the FSM is being cleared.
    always_comb begin
        sig_ready   = !sig_reset && (state != HOLD);
        sig_pkt_val = (state == HOLD);
    end

    // Packet buffer, length and error pulse. START wipes the whole buffer so
    // beats beyond the last stored one read back as zero. Stores use a
    // constant-index loop so the write slot never strays past the buffer.
    always_ff @(posedge sig_clock) begin
        if (sig_reset) begin
            pkt_buf   <= '0;
            beat_idx  <= '0;
            pkt_len   <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err_now;
            if (do_start) begin
                pkt_buf    <= '0;
                pkt_buf[0] <= beat_masked;
                beat_idx   <= IDX_W'(1);
                if (sig_i_eop && vbc_ok) begin
                    pkt_len <= sig_i_vbc;
                end
            end else if (do_store) begin
                for (int k = 0; k < MAX_BEATS; k++) begin
                    if (beat_idx == IDX_W'(k)) begin
                        pkt_buf[k] <= beat_masked;
                    end
                end
                if (sig_i_eop) begin
                    pkt_len <= len_next;
                end else begin
                    beat_idx <= beat_idx + IDX_W'(1);
                end
            end
        end
    end

    assign sig_pkt_data  = pkt_buf;
    assign sig_pkt_len   = pkt_len;
    assign sig_err_pulse = err_pulse;

    c3po_sink_sat_cnt #(
        .WIDTH (CNT_SIZE_P)
    ) u_cnt_pkt (
        .clock (sig_clock),
        .reset (sig_reset),
        .clr   (sig_clr_cnt),
        .inc   (pkt_take),
        .count (sig_cnt_pkt)
    );

    c3po_sink_sat_cnt #(
        .WIDTH (CNT_SIZE_P)
    ) u_cnt_err (
        .clock (sig_clock),
        .reset (sig_reset),
        .clr   (sig_clr_cnt),
        .inc   (err_now),
        .count (sig_cnt_err)
    );

endmodule
